// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control_pkg                                                     |
// | Opcodes, ALU select codes and FSM state encodings for multicycle_control.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package multicycle_control_pkg;

   localparam logic [6:0] c_op_r     = 7'b0110011;
   localparam logic [6:0] c_op_i_imm = 7'b0010011;
   localparam logic [6:0] c_op_i_lw  = 7'b0000011;
   localparam logic [6:0] c_op_s     = 7'b0100011;
   localparam logic [6:0] c_op_sb    = 7'b1100011;

   localparam logic [1:0] c_alu_add = 2'b00;
   localparam logic [1:0] c_alu_s   = 2'b01;
   localparam logic [1:0] c_alu_r   = 2'b10;
   localparam logic [1:0] c_alu_br  = 2'b11;

   localparam logic       c_src_a_pc  = 1'b0;
   localparam logic       c_src_a_rs1 = 1'b1;
   localparam logic [1:0] c_src_b_rs2 = 2'b00;
   localparam logic [1:0] c_src_b_4   = 2'b01;
   localparam logic [1:0] c_src_b_imm = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   function automatic logic op_is_legal(input logic [6:0] op);
      return op inside {c_op_r, c_op_i_imm, c_op_i_lw, c_op_s, c_op_sb};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_timeout_counter                                                         |
// | Memory-wait watchdog: expires on the TMO_CYC-th consecutive enabled cycle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_timeout_counter #(
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TMO_W-1:0] c_last = TMO_W'(TMO_CYC - 1);

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TMO_W'(1);
      end
   end

   // The cycle that would bring the count to TMO_CYC is the expiry cycle.
   assign o_expire = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control                                                         |
// | Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout + trap. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       op_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             i_or_d_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             branch_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             illegal_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [6:0]       r_op_q;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;
   logic             w_tmo_en;
   logic             w_tmo_expire;

   // Waiting means sitting in a memory state without a completion this cycle.
   assign w_tmo_en = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready_i;

   mc_timeout_counter #(
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
   ) u_timeout (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .i_clr    (!w_tmo_en),
      .i_en     (w_tmo_en),
      .o_expire (w_tmo_expire)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_op_q    <= '0;
         r_retired <= '0;
      end else begin
         if (r_state == ST_DECODE) begin
            r_op_q <= op_i;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_retire     = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      i_or_d_o     = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      branch_o     = 1'b0;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = c_src_a_pc;
      alu_src_b_o  = c_src_b_rs2;
      alu_op_o     = c_alu_add;
      illegal_o    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start_i) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = c_src_b_4;
            if (mem_ready_i) begin
               ir_write_o  = 1'b1;
               pc_write_o  = 1'b1;
               w_state_nxt = ST_DECODE;
            end else if (w_tmo_expire) begin
               w_state_nxt = ST_TRAP;
            end
         end
         ST_DECODE: begin
            w_state_nxt = op_is_legal(op_i) ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            alu_src_a_o = c_src_a_rs1;
            case (r_op_q)
               c_op_r: begin
                  alu_op_o    = c_alu_r;
                  w_state_nxt = ST_WB;
               end
               c_op_i_imm: begin
                  alu_src_b_o = c_src_b_imm;
                  w_state_nxt = ST_WB;
               end
               c_op_i_lw, c_op_s: begin
                  alu_src_b_o = c_src_b_imm;
                  w_state_nxt = ST_MEM;
               end
               c_op_sb: begin
                  alu_op_o = c_alu_br;
                  branch_o = 1'b1;
                  w_retire = 1'b1;
               end
               default: w_state_nxt = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            mem_req_o = 1'b1;
            i_or_d_o  = 1'b1;
            mem_we_o  = (r_op_q == c_op_s);
            if (mem_ready_i) begin
               if (r_op_q == c_op_s) w_retire = 1'b1;
               else                  w_state_nxt = ST_WB;
            end else if (w_tmo_expire) begin
               w_state_nxt = ST_TRAP;
            end
         end
         ST_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = (r_op_q == c_op_i_lw);
            w_retire     = 1'b1;
         end
         ST_TRAP: begin
            illegal_o = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Instruction boundary: the only place start_i is consulted after IDLE.
      if (w_retire) begin
         w_state_nxt = start_i ? ST_FETCH : ST_IDLE;
      end
   end

   assign state_o   = r_state;
   assign retired_o = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_control                                                      |
// | Instruction-level reference model feeding a per-cycle output scoreboard.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

   localparam int CNT_W   = 8;
   localparam int TMO_W   = 4;
   localparam int TMO_CYC = 4;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef struct packed {
      logic [2:0]       state;
      logic             mem_req;
      logic             mem_we;
      logic             i_or_d;
      logic             ir_write;
      logic             pc_write;
      logic             branch;
      logic             reg_write;
      logic             mem_to_reg;
      logic             src_a;
      logic [1:0]       src_b;
      logic [1:0]       alu_op;
      logic             illegal;
      logic [CNT_W-1:0] retired;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst_i = 1'b0;
   logic             start_i = 1'b0;
   logic [6:0]       op_i = '0;
   logic             mem_ready_i = 1'b0;
   logic             mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
   logic             branch_o, reg_write_o, mem_to_reg_o, alu_src_a_o, illegal_o;
   logic [1:0]       alu_src_b_o, alu_op_o;
   logic [2:0]       state_o;
   logic [CNT_W-1:0] retired_o;

   rec_t             exp_q[$];
   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] m_cnt = '0;
   bit               at_idle = 1'b1;
   bit               trapped = 1'b0;
   int               rst_cd = -1;

   multicycle_control #(
      .CNT_W   (CNT_W),
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .op_i         (op_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .i_or_d_o     (i_or_d_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .branch_o     (branch_o),
      .reg_write_o  (reg_write_o),
      .mem_to_reg_o (mem_to_reg_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o),
      .retired_o    (retired_o)
   );

   always #5 clk = ~clk;

   // Monitor: every cycle with a pending expectation is compared mid-cycle.
   always @(negedge clk) begin
      rec_t e;
      rec_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.state      = state_o;
         a.mem_req    = mem_req_o;
         a.mem_we     = mem_we_o;
         a.i_or_d     = i_or_d_o;
         a.ir_write   = ir_write_o;
         a.pc_write   = pc_write_o;
         a.branch     = branch_o;
         a.reg_write  = reg_write_o;
         a.mem_to_reg = mem_to_reg_o;
         a.src_a      = alu_src_a_o;
         a.src_b      = alu_src_b_o;
         a.alu_op     = alu_op_o;
         a.illegal    = illegal_o;
         a.retired    = retired_o;
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL outputs @%0t: got %h (state %0d retired %0d) want %h (state %0d retired %0d)",
                     $time, a, a.state, a.retired, e, e.state, e.retired);
         end
      end
   end

   function automatic rec_t mk(input logic [2:0] st);
      rec_t r;
      r         = '0;
      r.state   = st;
      r.illegal = (st == 3'd6);
      r.retired = m_cnt;
      return r;
   endfunction

   function automatic logic [6:0] rnd7();
      return 7'($urandom);
   endfunction

   function automatic bit legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
   endfunction

   function automatic logic [6:0] pick_legal();
      logic [6:0] ops [5];
      ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR};
      return ops[$urandom_range(0, 4)];
   endfunction

   // Called just after a rising edge; holds reset for two cycles, releases in the third.
   task automatic do_reset();
      rst_cd      = -1;
      m_cnt       = '0;
      rst_i       = 1'b0;
      start_i     = 1'($urandom);
      op_i        = rnd7();
      mem_ready_i = 1'($urandom);
      exp_q.push_back(mk(3'd0));
      @(posedge clk); #1;
      start_i     = 1'($urandom);
      mem_ready_i = 1'($urandom);
      exp_q.push_back(mk(3'd0));
      @(posedge clk); #1;
      rst_i   = 1'b1;
      start_i = 1'b0;
      exp_q.push_back(mk(3'd0));
      at_idle = 1'b1;
      trapped = 1'b0;
   endtask

   task automatic step(input rec_t e, input logic st, input logic [6:0] op,
                       input logic rdy, output bit ab);
      @(posedge clk); #1;
      if (rst_cd == 0) begin
         do_reset();
         ab = 1'b1;
      end else begin
         if (rst_cd > 0) rst_cd--;
         start_i     = st;
         op_i        = op;
         mem_ready_i = rdy;
         exp_q.push_back(e);
         ab = 1'b0;
      end
   endtask

   task automatic retire(input bit start_end);
      m_cnt   = m_cnt + 1'b1;
      at_idle = !start_end;
   endtask

   // One instruction: f_lat / m_lat = not-ready cycles before memory completes.
   task automatic run_instr(input logic [6:0] op, input int f_lat, input int m_lat,
                            input bit start_end, input int idle_n);
      bit   ab;
      rec_t e;
      logic rdy;
      int   w;
      if (trapped) return;
      if (at_idle) begin
         for (int i = 0; i < idle_n; i++) begin
            step(mk(3'd0), 1'b0, rnd7(), 1'($urandom), ab);
            if (ab) return;
         end
         step(mk(3'd0), 1'b1, rnd7(), 1'($urandom), ab);
         if (ab) return;
      end
      w = 0;
      while (1) begin
         rdy        = (w == f_lat);
         e          = mk(3'd1);
         e.mem_req  = 1'b1;
         e.src_b    = 2'b01;
         e.ir_write = rdy;
         e.pc_write = rdy;
         step(e, 1'($urandom), rnd7(), rdy, ab);
         if (ab) return;
         if (rdy) break;
         if (w == TMO_CYC - 1) begin trapped = 1'b1; return; end
         w++;
      end
      step(mk(3'd2), 1'($urandom), op, 1'($urandom), ab);
      if (ab) return;
      if (!legal(op)) begin trapped = 1'b1; return; end
      e       = mk(3'd3);
      e.src_a = 1'b1;
      if (op == OP_R)  e.alu_op = 2'b10;
      if (op == OP_I || op == OP_LW || op == OP_SW) e.src_b = 2'b10;
      if (op == OP_BR) begin e.alu_op = 2'b11; e.branch = 1'b1; end
      step(e, (op == OP_BR) ? start_end : 1'($urandom), rnd7(), 1'($urandom), ab);
      if (ab) return;
      if (op == OP_BR) begin retire(start_end); return; end
      if (op == OP_LW || op == OP_SW) begin
         w = 0;
         while (1) begin
            rdy      = (w == m_lat);
            e        = mk(3'd4);
            e.mem_req = 1'b1;
            e.i_or_d  = 1'b1;
            e.mem_we  = (op == OP_SW);
            step(e, (rdy && op == OP_SW) ? start_end : 1'($urandom), rnd7(), rdy, ab);
            if (ab) return;
            if (rdy) break;
            if (w == TMO_CYC - 1) begin trapped = 1'b1; return; end
            w++;
         end
         if (op == OP_SW) begin retire(start_end); return; end
      end
      e            = mk(3'd5);
      e.reg_write  = 1'b1;
      e.mem_to_reg = (op == OP_LW);
      step(e, start_end, rnd7(), 1'($urandom), ab);
      if (ab) return;
      retire(start_end);
   endtask

   task automatic trap_cycles(input int n);
      bit ab;
      for (int i = 0; i < n; i++) begin
         if (!trapped) return;
         step(mk(3'd6), 1'b1, rnd7(), 1'($urandom), ab);
         if (ab) return;
      end
   endtask

   task automatic reset_now();
      @(posedge clk); #1;
      do_reset();
   endtask

   initial begin
      reset_now();
      run_instr(OP_R,  0, 0, 1'b1, 0);
      run_instr(OP_LW, 0, 3, 1'b1, 0);
      run_instr(OP_SW, 0, 0, 1'b1, 0);
      run_instr(OP_BR, 0, 0, 1'b1, 0);
      run_instr(OP_I,  1, 0, 1'b0, 0);
      run_instr(OP_R,  3, 0, 1'b1, 2);
      run_instr(OP_R,  4, 0, 1'b1, 0);
      trap_cycles(50);
      reset_now();
      run_instr(7'b1111111, 0, 0, 1'b1, 1);
      trap_cycles(50);
      reset_now();
      run_instr(OP_LW, 0, 4, 1'b1, 0);
      trap_cycles(5);
      reset_now();
      rst_cd = 5;
      run_instr(OP_LW, 0, 3, 1'b1, 0);
      run_instr(OP_R,  0, 0, 1'b1, 0);

      // Long trap-free stretch so the retired counter wraps.
      for (int i = 0; i < 300; i++) begin
         run_instr(pick_legal(), $urandom_range(0, TMO_CYC - 1), $urandom_range(0, TMO_CYC - 1),
                   ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
      end

      // Mixed phase: illegal opcodes, timeouts and asynchronous resets.
      for (int i = 0; i < 300; i++) begin
         logic [6:0] op;
         int         fl;
         int         ml;
         op = ($urandom_range(0, 15) == 0) ? rnd7() : pick_legal();
         fl = ($urandom_range(0, 19) == 0) ? TMO_CYC : $urandom_range(0, 2);
         ml = ($urandom_range(0, 19) == 0) ? TMO_CYC : $urandom_range(0, 2);
         if (rst_cd < 0 && $urandom_range(0, 39) == 0) rst_cd = $urandom_range(0, 6);
         run_instr(op, fl, ml, ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
         if (trapped) begin
            trap_cycles($urandom_range(1, 5));
            if (trapped) reset_now();
         end
      end

      @(negedge clk); #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
